// File: rtl/mult_booth_r4_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM state encoding, Booth digits
// and the iteration-count helper.
package mult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    // Operands are extended by two bits, so (WIDTH+2)/2 radix-4 steps cover them.
    function automatic int iter_of(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/mult_booth_r4_if.sv
// Start/operand/result bundle between the ALU control FSM and the Booth multiplier.
interface mult_booth_r4_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_SIGNED;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             data_inputRDY;
    logic             data_resultRDY;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_result_hi;
    logic             data_exception;

    modport master (
        output ctrl_MULT, ctrl_SIGNED, data_operandA, data_operandB,
        input  data_inputRDY, data_resultRDY, data_result, data_result_hi, data_exception
    );

    modport slave (
        input  ctrl_MULT, ctrl_SIGNED, data_operandA, data_operandB,
        output data_inputRDY, data_resultRDY, data_result, data_result_hi, data_exception
    );
endinterface

// File: rtl/mult_booth_r4_recode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a digit and expands it
// into a partial-product select; negative digits are one's complement plus carry-in.
module booth_r4_recode
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] mcand,
    output booth_digit_e     digit,
    output logic [WIDTH+1:0] pp_sel,
    output logic             neg
);

    // Window {b[2i+1], b[2i], b[2i-1]} to digit.
    always_comb begin
        digit = ZERO;
        case (window)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

    // Digit to partial-product select and two's-complement carry-in.
    always_comb begin
        pp_sel = {(WIDTH+2){1'b0}};
        neg    = 1'b0;
        case (digit)
            POS1: begin
                pp_sel = mcand;
                neg    = 1'b0;
            end
            POS2: begin
                pp_sel = {mcand[WIDTH:0], 1'b0};
                neg    = 1'b0;
            end
            NEG1: begin
                pp_sel = ~mcand;
                neg    = 1'b1;
            end
            NEG2: begin
                pp_sel = ~{mcand[WIDTH:0], 1'b0};
                neg    = 1'b1;
            end
            default: begin
                pp_sel = {(WIDTH+2){1'b0}};
                neg    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_booth_r4.sv
// Multi-cycle radix-4 Booth multiplier, signed or unsigned, full 2*WIDTH-bit product
// after a fixed ITER-cycle latency, with an informational overflow flag.
module mult_booth_r4
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    mult_booth_r4_if.slave bus
);

    localparam int ITER = iter_of(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER + 1);

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [AW-1:0]      acc_r;
    logic [EW-1:0]      mcand_r;
    logic               prev_r;
    logic               signed_r;
    logic               input_rdy_r;
    logic               result_rdy_r;
    logic [WIDTH-1:0]   result_lo_r;
    logic [WIDTH-1:0]   result_hi_r;
    logic               exception_r;

    logic [EW-1:0]      a_ext_s;
    logic [EW-1:0]      b_ext_s;
    booth_digit_e       digit_s;
    logic [EW-1:0]      pp_sel_s;
    logic               neg_s;
    logic [EW-1:0]      sum_s;
    logic signed [AW-1:0] pre_shift_s;
    logic [AW-1:0]      acc_step_s;
    logic               last_iter_s;
    logic               unused_s;

    // Overflow against a WIDTH-bit destination, by mode of the latched operation.
    function automatic logic overflow_of(input logic [2*WIDTH-1:0] prod, input logic sgn);
        logic [WIDTH:0] top;
        top = prod[2*WIDTH-1:WIDTH-1];
        if (sgn) begin
            return !((&top) || !(|top));
        end else begin
            return |prod[2*WIDTH-1:WIDTH];
        end
    endfunction

    assign a_ext_s = {{2{bus.ctrl_SIGNED & bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
    assign b_ext_s = {{2{bus.ctrl_SIGNED & bus.data_operandB[WIDTH-1]}}, bus.data_operandB};

    booth_r4_recode #(
        .WIDTH (WIDTH)
    ) u_recode (
        .window (acc_r[1:0] == 2'b00 && !prev_r ? 3'b000 : {acc_r[1:0], prev_r}),
        .mcand  (mcand_r),
        .digit  (digit_s),
        .pp_sel (pp_sel_s),
        .neg    (neg_s)
    );

    // One Booth step: add the partial product to the upper half, then shift right by two.
    always_comb begin
        sum_s       = acc_r[AW-1:EW] + pp_sel_s + {{(EW-1){1'b0}}, neg_s};
        pre_shift_s = {sum_s, acc_r[EW-1:0]};
        acc_step_s  = pre_shift_s >>> 2;
        last_iter_s = (cnt_r == CW'(ITER - 1));
    end

    assign unused_s = ^{acc_step_s[AW-1:2*WIDTH], digit_s};

    // Control FSM, iteration counter, accumulator and registered result outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            acc_r        <= {AW{1'b0}};
            mcand_r      <= {EW{1'b0}};
            prev_r       <= 1'b0;
            signed_r     <= 1'b0;
            input_rdy_r  <= 1'b1;
            result_rdy_r <= 1'b0;
            result_lo_r  <= {WIDTH{1'b0}};
            result_hi_r  <= {WIDTH{1'b0}};
            exception_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.ctrl_MULT) begin
                        state_r      <= ST_BUSY;
                        cnt_r        <= {CW{1'b0}};
                        acc_r        <= {{EW{1'b0}}, b_ext_s};
                        mcand_r      <= a_ext_s;
                        prev_r       <= 1'b0;
                        signed_r     <= bus.ctrl_SIGNED;
                        input_rdy_r  <= 1'b0;
                        result_rdy_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_BUSY: begin
                    acc_r  <= acc_step_s;
                    prev_r <= acc_r[1];
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_iter_s) begin
                        state_r      <= ST_DONE;
                        input_rdy_r  <= 1'b1;
                        result_rdy_r <= 1'b1;
                        result_lo_r  <= acc_step_s[WIDTH-1:0];
                        result_hi_r  <= acc_step_s[2*WIDTH-1:WIDTH];
                        exception_r  <= overflow_of(acc_step_s[2*WIDTH-1:0], signed_r);
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    input_rdy_r  <= 1'b1;
                    result_rdy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_inputRDY  = input_rdy_r;
    assign bus.data_resultRDY = result_rdy_r;
    assign bus.data_result    = result_lo_r;
    assign bus.data_result_hi = result_hi_r;
    assign bus.data_exception = exception_r;

endmodule
